tpu_wb_master: RTL and testbench



---
 rtl/edu_tpu_pkg.sv | 26 ++
 rtl/tpu_wb_master_if.sv | 23 ++
 rtl/tpu_wb_watchdog.sv | 25 ++
 rtl/tpu_wb_master.sv | 138 +++++++++++++
 tb/tb_tpu_wb_master.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/edu_tpu_pkg.sv
// Shared types and defaults for the edu_tpu Wishbone initiator.
package edu_tpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_SETTLE,
    ST_READ,
    ST_RESULT
  } state_t;

  localparam word_t DEF_BASE_ADDRESS  = 32'h3000_0000;
  localparam int    DEF_N_WEIGHT      = 4;
  localparam int    DEF_N_INPUT       = 6;
  localparam int    DEF_N_RESULT      = 5;
  localparam int    DEF_SETTLE_CYCLES = 32;
  localparam int    DEF_TIMEOUT       = 255;

  // Word counter width; job sizes must stay below 2**CNT_W.
  localparam int    CNT_W             = 8;

endpackage

// File: rtl/tpu_wb_master_if.sv
// Wishbone classic bus between the initiator and the accelerator responder.
interface tpu_wb_master_if;
  import edu_tpu_pkg::*;

  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [3:0] wb_sel_o;
  word_t      wb_adr_o;
  word_t      wb_dat_o;
  word_t      wb_dat_i;
  logic       wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/tpu_wb_watchdog.sv
// Bus watchdog: counts strobe cycles without ack, flags expiry on the last one.
module tpu_wb_watchdog #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  // Count waiting cycles; clear takes priority so every new strobe starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  // Asserted during the LIMIT-th waiting cycle so the strobe lasts exactly LIMIT cycles.
  assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/tpu_wb_master.sv
// Wishbone classic initiator: streams weights/inputs into edu_tpu, then reads results.
module tpu_wb_master
  import edu_tpu_pkg::*;
#(
  parameter word_t BASE_ADDRESS  = DEF_BASE_ADDRESS,
  parameter int    N_WEIGHT      = DEF_N_WEIGHT,
  parameter int    N_INPUT       = DEF_N_INPUT,
  parameter int    N_RESULT      = DEF_N_RESULT,
  parameter int    SETTLE_CYCLES = DEF_SETTLE_CYCLES,  // must be >= 1
  parameter int    TIMEOUT       = DEF_TIMEOUT         // must be 1..256
) (
  input  logic  wb_clk_i,
  input  logic  wb_rst_n_i,
  input  logic  start_i,
  input  logic  src_valid_i,
  input  word_t src_data_i,
  output logic  src_ready_o,
  output logic  res_valid_o,
  output word_t res_data_o,
  input  logic  res_ready_i,
  output logic  busy_o,
  output logic  done_o,
  output logic  err_o,
  tpu_wb_master_if.master bus
);

  // Weights and inputs share one address; the counter alone separates the phases.
  localparam logic [CNT_W-1:0] N_WORDS_C   = CNT_W'(N_WEIGHT + N_INPUT);
  localparam logic [CNT_W-1:0] N_RESULT_C  = CNT_W'(N_RESULT);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [15:0]      scnt;
  word_t            wdat_q, rdat_q;
  logic             cyc_q, stb_q, we_q, busy_q, done_q, err_q, rvld_q;
  logic             cyc_d, stb_d, we_d, busy_d, done_d, err_d, rvld_d;
  logic             ack, accept, wd_expired;

  // A lingering registered ack after stb falls must never count.
  assign ack     = bus.wb_ack_i && stb_q;
  assign cnt_inc = cnt + 1'b1;
  // done_q blocks a start that coincides with the completion pulse.
  assign accept  = (state == ST_IDLE) && start_i && !done_q;

  tpu_wb_watchdog #(.LIMIT(TIMEOUT), .W(8)) u_wd (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .clr     (!stb_q),
    .en      (stb_q && !bus.wb_ack_i),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= ST_IDLE;
    else             state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) nxt = ST_FETCH;
      ST_FETCH:  if (src_valid_i) nxt = ST_WRITE;
      ST_WRITE:  if (ack) nxt = ST_GAP;
                 else if (wd_expired) nxt = ST_IDLE;
      ST_GAP:    nxt = (cnt < N_WORDS_C) ? ST_FETCH : ST_SETTLE;
      ST_SETTLE: if (scnt == SETTLE_LAST) nxt = ST_READ;
      ST_READ:   if (ack) nxt = ST_RESULT;
                 else if (wd_expired) nxt = ST_IDLE;
      ST_RESULT: if (res_ready_i) nxt = (cnt_inc < N_RESULT_C) ? ST_READ : ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Output decode: next-cycle values for the registered outputs, plus src_ready.
  always_comb begin
    cyc_d       = (nxt == ST_WRITE) || (nxt == ST_READ);
    stb_d       = cyc_d;
    we_d        = (nxt == ST_WRITE);
    busy_d      = (nxt != ST_IDLE);
    done_d      = (state == ST_RESULT) && (nxt == ST_IDLE);
    err_d       = err_q;
    if (accept)     err_d = 1'b0;
    if (wd_expired) err_d = 1'b1;
    rvld_d      = rvld_q;
    if ((state == ST_READ) && ack)           rvld_d = 1'b1;
    if ((state == ST_RESULT) && res_ready_i) rvld_d = 1'b0;
    if (wd_expired)                          rvld_d = 1'b0;
    src_ready_o = (state == ST_FETCH);
  end

  // Output registers and datapath (counters, write/read data).
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rvld_q <= 1'b0;
      cnt    <= '0;
      scnt   <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      stb_q  <= stb_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      rvld_q <= rvld_d;
      scnt   <= (state == ST_SETTLE) ? scnt + 1'b1 : '0;
      if (accept)                              cnt <= '0;
      if ((state == ST_WRITE) && ack)          cnt <= cnt_inc;
      if ((state == ST_GAP) && (nxt == ST_SETTLE)) cnt <= '0;
      if ((state == ST_RESULT) && res_ready_i) cnt <= cnt_inc;
      if ((state == ST_FETCH) && src_valid_i)  wdat_q <= src_data_i;
      if ((state == ST_READ) && ack)           rdat_q <= bus.wb_dat_i;
    end
  end

  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = stb_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_sel_o = stb_q ? 4'hF : 4'h0;
  assign bus.wb_adr_o = BASE_ADDRESS;
  assign bus.wb_dat_o = wdat_q;
  assign res_valid_o  = rvld_q;
  assign res_data_o   = rdat_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_tpu_wb_master.sv
// Directed bench for tpu_wb_master with a configurable Wishbone responder model.
module tb_tpu_wb_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        start_i;
  logic        src_valid_i;
  logic [31:0] src_data_i;
  logic        src_ready_o;
  logic        res_valid_o;
  logic [31:0] res_data_o;
  logic        res_ready_i;
  logic        busy_o, done_o, err_o;

  tpu_wb_master_if wb ();

  tpu_wb_master dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n_i  (wb_rst_n_i),
    .start_i     (start_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_ready_i (res_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .bus         (wb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] src_words [0:9] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10,
                                   32'd11, 32'd12, 32'd13, 32'd14, 32'd15};

  // Bench knobs, written only by the main sequence.
  int ack_mode = 0;   // 0 zero-wait, 1 registered ack, 2 never ack 3rd write, 3 never ack
  int src_gap  = 0;
  int res_hold = 0;
  int feed_gen = 0;
  int wr_base = 0, rd_base = 0, res_base = 0, done_base = 0, rise_base = 0;

  // Bus/stream monitor state.
  int          cyc_no = 0, wr_total = 0, rd_total = 0, res_total = 0, done_total = 0;
  int          rises = 0, run = 0, last_run = 0, viol = 0;
  logic        stb_prev = 1'b0, ack_reg = 1'b0;
  logic [31:0] wr_mem [0:127];
  int          wr_cyc [0:127];
  int          rd_cyc [0:127];
  logic [31:0] res_mem [0:127];

  logic blocked;
  assign blocked = (ack_mode == 3) ||
                   ((ack_mode == 2) && wb.wb_we_o && ((wr_total - wr_base) == 2));
  assign wb.wb_ack_i = !blocked &&
                       ((ack_mode == 1) ? ack_reg : (wb.wb_cyc_o && wb.wb_stb_o));
  assign wb.wb_dat_i = 32'hA0 + 32'(rd_total - rd_base);

  always @(posedge wb_clk_i) begin
    cyc_no   <= cyc_no + 1;
    ack_reg  <= wb.wb_cyc_o && wb.wb_stb_o;
    stb_prev <= wb.wb_stb_o;
    if (wb.wb_stb_o && !stb_prev) rises <= rises + 1;
    if (wb.wb_stb_o) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
    if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
      if (wb.wb_we_o) begin
        wr_mem[wr_total & 127] <= wb.wb_dat_o;
        wr_cyc[wr_total & 127] <= cyc_no;
        wr_total <= wr_total + 1;
      end else begin
        rd_cyc[rd_total & 127] <= cyc_no;
        rd_total <= rd_total + 1;
      end
    end
    if (res_valid_o && res_ready_i) begin
      res_mem[res_total & 127] <= res_data_o;
      res_total <= res_total + 1;
    end
    if (done_o) done_total <= done_total + 1;
    if (wb.wb_stb_o && !wb.wb_we_o && res_valid_o) viol <= viol + 1;
  end

  // Source: offers src_words in order, with src_gap idle cycles after each handshake.
  initial begin
    int idx = 0, gap = 0, gen = 0;
    bit hs = 0;
    src_valid_i = 1'b0;
    src_data_i  = '0;
    forever begin
      @(negedge wb_clk_i);
      if (gen != feed_gen) begin
        gen = feed_gen; idx = 0; gap = 0; hs = 0; src_valid_i = 1'b0;
      end
      if (hs) begin idx++; gap = src_gap; src_valid_i = 1'b0; end
      if (!src_valid_i && idx < 10) begin
        if (gap > 0) gap--;
        else begin src_valid_i = 1'b1; src_data_i = src_words[idx]; end
      end
      hs = src_valid_i && src_ready_o;
    end
  end

  // Result sink: raises ready res_hold cycles after a result appears.
  initial begin
    int h = 0;
    res_ready_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (!res_valid_o) begin res_ready_i = 1'b0; h = 0; end
      else if (!res_ready_i) begin
        if (h >= res_hold) res_ready_i = 1'b1;
        else h++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
  endtask

  task automatic new_job(input int mode, input int gap, input int hold);
    @(negedge wb_clk_i);
    ack_mode = mode; src_gap = gap; res_hold = hold;
    wr_base = wr_total; rd_base = rd_total; res_base = res_total;
    done_base = done_total; rise_base = rises;
    feed_gen++;
    @(negedge wb_clk_i);
  endtask

  task automatic pulse_start();
    @(negedge wb_clk_i);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
  endtask

  // which: 0 done_o, 1 err_o, 2 stb, 3 all ten writes acked
  task automatic wait_for(input int which, input int lim, output bit hit);
    hit = 0;
    for (int c = 0; c < lim && !hit; c++) begin
      @(negedge wb_clk_i);
      case (which)
        0: hit = done_o;
        1: hit = err_o;
        2: hit = wb.wb_stb_o;
        default: hit = (wr_total - wr_base) >= 10;
      endcase
    end
  endtask

  task automatic check_job(input string tag);
    for (int i = 0; i < 10; i++) chk({tag, "_wr_data"}, wr_mem[wr_base + i], src_words[i]);
    for (int i = 0; i < 5; i++)  chk({tag, "_res_data"}, res_mem[res_base + i], 32'hA0 + i);
    chk({tag, "_writes"}, wr_total - wr_base, 10);
    chk({tag, "_reads"}, rd_total - rd_base, 5);
    chk({tag, "_strobes"}, rises - rise_base, 15);
    chk({tag, "_done_cnt"}, done_total - done_base, 1);
    chk({tag, "_busy_end"}, {31'd0, busy_o}, 0);
    chk({tag, "_err_end"}, {31'd0, err_o}, 0);
  endtask

  initial begin
    bit hit;
    start_i    = 1'b0;
    wb_rst_n_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ctrl", {28'd0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, src_ready_o}, 0);
    chk("rst_sel", {28'd0, wb.wb_sel_o}, 0);
    chk("rst_adr", wb.wb_adr_o, 32'h3000_0000);
    chk("rst_dat", wb.wb_dat_o, 0);
    chk("rst_flags", {28'd0, busy_o, done_o, err_o, res_valid_o}, 0);
    chk("rst_res_data", res_data_o, 0);
    wb_rst_n_i = 1'b1;

    // Job A: zero-wait responder, no backpressure.
    new_job(0, 0, 0);
    pulse_start();
    chk("A_busy_next", {31'd0, busy_o}, 1);
    chk("A_fetch_ready", {31'd0, src_ready_o}, 1);
    wait_for(0, 2000, hit);
    chk("A_done_seen", {31'd0, hit}, 1);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check_job("A");
    chk("A_write_pace", wr_cyc[wr_base + 9] - wr_cyc[wr_base], 27);
    chk("A_settle_min", {31'd0, (rd_cyc[rd_base] - wr_cyc[wr_base + 9]) > 32}, 1);

    // Job B: registered ack lingering one cycle after stb falls.
    new_job(1, 0, 0);
    pulse_start();
    wait_for(0, 2000, hit);
    chk("B_done_seen", {31'd0, hit}, 1);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check_job("B");

    // Job C: source gaps and slow result sink.
    new_job(0, 3, 4);
    pulse_start();
    wait_for(0, 3000, hit);
    chk("C_done_seen", {31'd0, hit}, 1);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check_job("C");
    chk("C_read_while_valid", viol, 0);

    // Job T: third write never acked -> timeout abort.
    new_job(2, 0, 0);
    pulse_start();
    wait_for(1, 2000, hit);
    chk("T_err_seen", {31'd0, hit}, 1);
    chk("T_bus_idle", {29'd0, wb.wb_cyc_o, wb.wb_stb_o, busy_o}, 0);
    chk("T_res_valid", {31'd0, res_valid_o}, 0);
    repeat (3) @(negedge wb_clk_i);
    chk("T_stb_len", last_run, 255);
    chk("T_writes", wr_total - wr_base, 2);
    chk("T_no_done", done_total - done_base, 0);
    chk("T_err_sticky", {31'd0, err_o}, 1);

    // Restart after timeout clears err and completes.
    new_job(0, 0, 0);
    pulse_start();
    chk("R_err_cleared", {31'd0, err_o}, 0);
    wait_for(0, 2000, hit);
    chk("R_done_seen", {31'd0, hit}, 1);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    check_job("R");

    // start_i during SETTLE is ignored.
    new_job(0, 0, 0);
    pulse_start();
    wait_for(3, 1000, hit);
    chk("S_writes_seen", {31'd0, hit}, 1);
    repeat (5) @(negedge wb_clk_i);
    pulse_start();
    wait_for(0, 2000, hit);
    chk("S_done_seen", {31'd0, hit}, 1);
    repeat (100) @(negedge wb_clk_i);
    check_job("S");

    // Reset asserted mid-WRITE releases the bus asynchronously.
    new_job(3, 0, 0);
    pulse_start();
    wait_for(2, 100, hit);
    chk("X_stb_seen", {31'd0, hit}, 1);
    @(negedge wb_clk_i);
    #2 wb_rst_n_i = 1'b0;
    #1 chk("X_async_drop", {29'd0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 0);
    @(negedge wb_clk_i);
    chk("X_flags", {27'd0, busy_o, done_o, err_o, res_valid_o, src_ready_o}, 0);
    chk("X_sel", {28'd0, wb.wb_sel_o}, 0);
    chk("X_adr", wb.wb_adr_o, 32'h3000_0000);
    chk("X_dat", wb.wb_dat_o, 0);
    wb_rst_n_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
